csa_stream_accumulator: RTL and testbench



---
 rtl/csa_stream_accumulator.sv | 162 ++++++++++++++++
 tb/tb_csa_stream_accumulator.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_stream_accumulator.sv
// Streaming carry-save accumulator: one 3:2 row per operand beat,
// followed by a chunked multi-cycle carry-propagate resolve.
module csa_stream_accumulator #(
  parameter int WIDTH = 21,
  parameter int GUARD = 4,
  parameter int CHUNK = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH+GUARD-1:0] out_data,
  output logic [GUARD:0]         out_count,
  output logic                   out_overflow
);

  localparam int AW  = WIDTH + GUARD;
  localparam int NCH = (AW + CHUNK - 1) / CHUNK;
  localparam int PW  = NCH * CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = GUARD + 1;

  typedef enum logic [1:0] {
    ACCUM,
    RESOLVE,
    OUT
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   s_q, s_d;
  logic [AW-1:0]   c_q, c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [AW-1:0]   res_q, res_d;
  logic [KW-1:0]   k_q, k_d;
  logic            cy_q, cy_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [AW-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]   out_count_q, out_count_d;
  logic            out_ovf_q, out_ovf_d;

  logic [AW-1:0]   x;
  logic [AW-2:0]   maj;
  logic [PW-1:0]   s_pad;
  logic [PW-1:0]   c_pad;
  logic [CHUNK:0]  sum;
  int              base;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    res_d       = res_q;
    k_d         = k_q;
    cy_d        = cy_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    x     = AW'(in_data);
    maj   = (s_q[AW-2:0] & c_q[AW-2:0])
          | (s_q[AW-2:0] & x[AW-2:0])
          | (c_q[AW-2:0] & x[AW-2:0]);
    s_pad = PW'(s_q);
    c_pad = PW'(c_q);
    base  = int'(k_q) * CHUNK;
    sum   = {1'b0, s_pad[base +: CHUNK]}
          + {1'b0, c_pad[base +: CHUNK]}
          + (CHUNK+1)'(cy_q);

    unique case (state_q)
      ACCUM: begin
        if (in_valid && in_ready_q) begin
          s_d = s_q ^ c_q ^ x;
          c_d = {maj, 1'b0};
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(2**GUARD)) ovf_d = 1'b1;
          if (in_last) begin
            state_d    = RESOLVE;
            k_d        = '0;
            cy_d       = 1'b0;
            in_ready_d = 1'b0;
          end
        end
      end
      RESOLVE: begin
        // top chunk bits beyond AW are dropped
        for (int i = 0; i < CHUNK; i++) begin
          if (base + i < AW) res_d[base+i] = sum[i];
        end
        cy_d = sum[CHUNK];
        k_d  = k_q + 1'b1;
        if (k_q == KW'(NCH-1)) state_d = OUT;
      end
      OUT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = res_q;
          out_count_d = cnt_q;
          out_ovf_d   = ovf_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          s_d         = '0;
          c_d         = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_q       <= '0;
      k_q         <= '0;
      cy_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      res_q       <= res_d;
      k_q         <= k_d;
      cy_q        <= cy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed bench for csa_stream_accumulator, including
// alternate CHUNK builds run side by side.
module tb_csa_stream_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_data;
  logic [4:0]  out_count;
  logic        out_overflow;

  logic        g_valid;
  logic [20:0] g_data;
  logic        g_last;
  logic        g_ready;
  logic        g_in_ready [4];
  logic        g_ov [4];
  logic [24:0] g_od [4];
  logic [4:0]  g_oc [4];
  logic        g_of [4];

  int checks;
  int errors;

  csa_stream_accumulator #(
    .WIDTH(21), .GUARD(4), .CHUNK(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count),
    .out_overflow(out_overflow)
  );

  for (genvar g = 0; g < 4; g++) begin : gc
    csa_stream_accumulator #(
      .WIDTH(21), .GUARD(4),
      .CHUNK(g == 0 ? 1 : g == 1 ? 7 : g == 2 ? 25 : 8)
    ) u (
      .clk(clk), .rst_n(rst_n),
      .in_valid(g_valid), .in_ready(g_in_ready[g]),
      .in_data(g_data), .in_last(g_last),
      .out_valid(g_ov[g]), .out_ready(g_ready),
      .out_data(g_od[g]), .out_count(g_oc[g]),
      .out_overflow(g_of[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [20:0] d, input logic l);
    int w;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    checks++;
    if (w >= 50) begin
      errors++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL out_timeout out_valid=%0b required=1", out_valid);
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs in_ready=%0b out_valid=%0b required 1 0",
               in_ready, out_valid);
    end
    checks++;
    if (out_data !== 25'h0 || out_count !== 5'd0 || out_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_out data=%h count=%0d ovf=%0b required 0 0 0",
               out_data, out_count, out_overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int lat;
    send(21'h1FFFFF, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_busy in_ready=%0b required=0", in_ready);
    end
    wait_out(lat);
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL single_latency got=%0d required=5", lat);
    end
    checks++;
    if (out_data !== 25'h01FFFFF || out_count !== 5'd1 || out_overflow !== 1'b0) begin
      errors++;
      $display("FAIL single_result data=%h count=%0d ovf=%0b required 01fffff 1 0",
               out_data, out_count, out_overflow);
    end
    take();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 25'h01FFFFF) begin
      errors++;
      $display("FAIL single_after ov=%0b ir=%0b data=%h required 0 1 01fffff",
               out_valid, in_ready, out_data);
    end
  endtask

  task automatic test_gapped();
    int lat;
    logic [20:0] v [3];
    v[0] = 21'h000005;
    v[1] = 21'h0ABCDE;
    v[2] = 21'h1FFFFF;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0;
      in_last  = 1'b1;
      in_data  = 21'h155555;
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk); #1;
      end
      send(v[i], i == 2);
    end
    wait_out(lat);
    checks++;
    if (out_data !== 25'h02ABCE2 || out_count !== 5'd3 || out_overflow !== 1'b0) begin
      errors++;
      $display("FAIL gapped data=%h count=%0d ovf=%0b required 02abce2 3 0",
               out_data, out_count, out_overflow);
    end
    take();
  endtask

  task automatic test_back_to_back();
    int lat;
    int stalls;
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      if (!in_ready) stalls++;
      send(21'h1FFFFF, i == 15);
    end
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL b2b_stalls got=%0d required=0", stalls);
    end
    wait_out(lat);
    checks++;
    if (out_data !== 25'h1FFFFF0 || out_count !== 5'd16 || out_overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b data=%h count=%0d ovf=%0b required 1fffff0 16 0",
               out_data, out_count, out_overflow);
    end
    take();
  endtask

  task automatic test_overflow_hold();
    int lat;
    int bad;
    for (int i = 0; i < 17; i++) send(21'h1FFFFF, i == 16);
    wait_out(lat);
    checks++;
    if (out_data !== 25'h01FFFEF || out_count !== 5'd17 || out_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow data=%h count=%0d ovf=%0b required 01fffef 17 1",
               out_data, out_count, out_overflow);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 25'h01FFFEF ||
          out_count !== 5'd17 || out_overflow !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable bad_cycles=%0d required=0", bad);
    end
    take();
    send(21'h000009, 1'b1);
    wait_out(lat);
    checks++;
    if (out_data !== 25'h0000009 || out_count !== 5'd1 || out_overflow !== 1'b0) begin
      errors++;
      $display("FAIL after_ovf data=%h count=%0d ovf=%0b required 0000009 1 0",
               out_data, out_count, out_overflow);
    end
    take();
  endtask

  task automatic test_reset_resolve();
    int lat;
    send(21'h001234, 1'b0);
    send(21'h000001, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 25'h0 ||
        out_count !== 5'd0 || out_overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset ir=%0b ov=%0b data=%h count=%0d ovf=%0b required 1 0 0 0 0",
               in_ready, out_valid, out_data, out_count, out_overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(21'h000003, 1'b0);
    send(21'h000004, 1'b1);
    wait_out(lat);
    checks++;
    if (out_data !== 25'h0000007 || out_count !== 5'd2) begin
      errors++;
      $display("FAIL post_reset data=%h count=%0d required 0000007 2",
               out_data, out_count);
    end
    take();
  endtask

  task automatic test_chunks();
    logic [20:0] v [2][3];
    logic [24:0] exp_sum [2];
    int nbeat [2];
    int nch [4];
    int lat [4];
    logic [24:0] got [4];
    nch[0] = 25; nch[1] = 4; nch[2] = 1; nch[3] = 4;
    v[0][0] = 21'h1FFFFF; v[0][1] = 21'h0ABCDE; v[0][2] = 21'h123456;
    v[1][0] = 21'h1FFFFF; v[1][1] = 21'h000001; v[1][2] = 21'h0;
    exp_sum[0] = 25'h03CF133;
    exp_sum[1] = 25'h0200000;
    nbeat[0] = 3;
    nbeat[1] = 2;
    g_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int b = 0; b < nbeat[s]; b++) begin
        g_valid = 1'b1;
        g_data  = v[s][b];
        g_last  = (b == nbeat[s] - 1);
        @(posedge clk); #1;
      end
      g_valid = 1'b0;
      g_last  = 1'b0;
      for (int i = 0; i < 4; i++) begin
        lat[i] = 0;
        got[i] = '0;
      end
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
          if (g_ov[i] && lat[i] == 0) begin
            lat[i] = c;
            got[i] = g_od[i];
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (lat[i] != nch[i] + 1 || got[i] !== exp_sum[s]) begin
          errors++;
          $display("FAIL chunk_inst%0d_sum%0d lat=%0d data=%h required %0d %h",
                   i, s, lat[i], got[i], nch[i] + 1, exp_sum[s]);
        end
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    g_valid   = 1'b0;
    g_data    = '0;
    g_last    = 1'b0;
    g_ready   = 1'b0;
    test_reset();
    test_single();
    test_gapped();
    test_back_to_back();
    test_overflow_hold();
    test_reset_resolve();
    test_chunks();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
